// File: rtl/snow64_bfloat16_vector_binop_sequencer_pkg.sv
// snow64_bfloat16_vector_binop_sequencer_pkg: shared types and lane-search helper for the vector sequencer
package snow64_bfloat16_vector_binop_sequencer_pkg;
    localparam int WIDTH__SNOW64_BFLOAT16_VEC_LANES = 4;
    typedef enum logic [1:0] {
        ST_VEC_SEQ_IDLE,
        ST_VEC_SEQ_ISSUE,
        ST_VEC_SEQ_WAIT,
        ST_VEC_SEQ_DONE
    } state_vec_bin_op_seq_t;
    typedef struct packed {
        logic [WIDTH__SNOW64_BFLOAT16_VEC_LANES-1:0] lane_mask;
        logic [63:0] a;
        logic [63:0] b;
    } port_in_vec_bin_op_t;
    typedef struct packed {
        logic can_accept_cmd;
        logic data_valid;
        logic [63:0] data;
    } port_out_vec_bin_op_t;
    function automatic logic [2:0] find_lane(input logic [3:0] mask, input logic [2:0] from);
        find_lane = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (mask[i] && 3'(i) >= from)
                find_lane = {1'b1, 2'(i)};
    endfunction
endpackage

// File: rtl/snow64_bfloat16_vector_binop_sequencer.sv
// snow64_bfloat16_vector_binop_sequencer: issues enabled bfloat16 lanes one at a time to a scalar binop unit
module snow64_bfloat16_vector_binop_sequencer
    import snow64_bfloat16_vector_binop_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_start,
    input  logic [3:0]  in_lane_mask,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    output logic        out_can_accept_cmd,
    output logic        out_data_valid,
    output logic [63:0] out_data,
    output logic        unit_start,
    output logic [15:0] unit_a,
    output logic [15:0] unit_b,
    input  logic        unit_can_accept_cmd,
    input  logic        unit_data_valid,
    input  logic [15:0] unit_data
);
    state_vec_bin_op_seq_t state;
    port_in_vec_bin_op_t   cmd;
    port_out_vec_bin_op_t  out;
    logic [1:0]  lane;
    logic [63:0] results;
    logic [2:0]  first_lane;
    logic [2:0]  next_lane;
    assign first_lane = find_lane(in_lane_mask, 3'd0);
    assign next_lane = find_lane(cmd.lane_mask, {1'b0, lane} + 3'd1);
    assign unit_start = state == ST_VEC_SEQ_ISSUE && unit_can_accept_cmd;
    assign unit_a = cmd.a[16*lane +: 16];
    assign unit_b = cmd.b[16*lane +: 16];
    assign out_can_accept_cmd = out.can_accept_cmd;
    assign out_data_valid = out.data_valid;
    assign out_data = out.data;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_VEC_SEQ_IDLE;
            cmd <= '0;
            out <= '{1'b1, 1'b0, 64'h0};
            lane <= 2'd0;
            results <= '0;
        end else begin
            case (state)
                ST_VEC_SEQ_IDLE:
                    if (in_start && out.can_accept_cmd) begin
                        cmd <= '{in_lane_mask, in_a, in_b};
                        out.data_valid <= 1'b0;
                        out.can_accept_cmd <= 1'b0;
                        lane <= first_lane[1:0];
                        results <= '0;
                        state <= first_lane[2] ? ST_VEC_SEQ_ISSUE : ST_VEC_SEQ_DONE;
                    end
                ST_VEC_SEQ_ISSUE:
                    if (unit_can_accept_cmd)
                        state <= ST_VEC_SEQ_WAIT;
                ST_VEC_SEQ_WAIT:
                    if (unit_data_valid && unit_can_accept_cmd) begin
                        results[16*lane +: 16] <= unit_data;
                        lane <= next_lane[1:0];
                        state <= next_lane[2] ? ST_VEC_SEQ_ISSUE : ST_VEC_SEQ_DONE;
                    end
                ST_VEC_SEQ_DONE: begin
                    out <= '{1'b1, 1'b1, results};
                    state <= ST_VEC_SEQ_IDLE;
                end
                default: state <= ST_VEC_SEQ_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snow64_bfloat16_vector_binop_sequencer.sv
// tb_snow64_bfloat16_vector_binop_sequencer: directed checks with a halving stub standing in for the scalar divider
module tb_snow64_bfloat16_vector_binop_sequencer;
    import snow64_bfloat16_vector_binop_sequencer_pkg::*;
    localparam logic [63:0] OP_A = 64'h4000_C080_3F80_40C0;
    localparam logic [63:0] OP_B = 64'h4000_4000_4000_4000;
    localparam logic [63:0] RES_FULL = 64'h3F80_C000_3F00_4040;
    localparam logic [63:0] RES_PART = 64'h0000_C000_0000_4040;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_start = 1'b0;
    logic [3:0] in_lane_mask = 4'h0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic out_can_accept_cmd, out_data_valid, unit_start;
    logic [63:0] out_data;
    logic [15:0] unit_a, unit_b, unit_data;
    logic unit_can_accept_cmd, unit_data_valid;
    logic hold = 1'b0;
    int lat = 1;
    logic busy = 1'b0;
    logic dv = 1'b0;
    int cnt = 0;
    logic [15:0] ra = '0;
    logic [15:0] ud = '0;
    int starts = 0;
    logic [15:0] issued [256];
    int checks = 0;
    int failures = 0;
    int k, s0, n;

    snow64_bfloat16_vector_binop_sequencer dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_lane_mask(in_lane_mask),
        .in_a(in_a), .in_b(in_b), .out_can_accept_cmd(out_can_accept_cmd),
        .out_data_valid(out_data_valid), .out_data(out_data), .unit_start(unit_start),
        .unit_a(unit_a), .unit_b(unit_b), .unit_can_accept_cmd(unit_can_accept_cmd),
        .unit_data_valid(unit_data_valid), .unit_data(unit_data)
    );

    always #5 clk = ~clk;

    // Stub unit: every operand pair uses b = 2.0, so halving is an exponent decrement.
    assign unit_can_accept_cmd = !busy && !hold;
    assign unit_data_valid = dv;
    assign unit_data = ud;
    always @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            dv <= 1'b0;
            cnt <= 0;
        end else begin
            dv <= 1'b0;
            if (unit_start) begin
                busy <= 1'b1;
                cnt <= lat;
                ra <= unit_a;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy <= 1'b0;
                    dv <= 1'b1;
                    ud <= {ra[15], ra[14:7] - 8'd1, ra[6:0]};
                end else
                    cnt <= cnt - 1;
            end
        end
    end

    always @(posedge clk)
        if (unit_start) begin
            issued[starts[7:0]] <= unit_a;
            starts <= starts + 1;
        end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] mask, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_start = 1'b1;
        in_lane_mask = mask;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_data_valid && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check("valid_seen", 64'(out_data_valid), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_accept", 64'(out_can_accept_cmd), 64'd1);
        check("rst_valid", 64'(out_data_valid), 64'd0);
        check("rst_data", out_data, 64'h0);
        check("rst_unit_start", 64'(unit_start), 64'd0);
        rst = 1'b0;

        s0 = starts;
        send(4'b1111, OP_A, OP_B);
        check("full_busy", 64'(out_can_accept_cmd), 64'd0);
        wait_valid(k);
        check("full_data", out_data, RES_FULL);
        check("full_starts", 64'(starts - s0), 64'd4);
        check("full_latency", 64'(k), 64'd17);
        check("full_accept_again", 64'(out_can_accept_cmd), 64'd1);

        s0 = starts;
        send(4'b0101, OP_A, OP_B);
        wait_valid(k);
        check("part_data", out_data, RES_PART);
        check("part_starts", 64'(starts - s0), 64'd2);
        check("part_lane0", 64'(issued[s0[7:0]]), 64'h40C0);
        check("part_lane2", 64'(issued[s0[7:0] + 8'd1]), 64'hC080);
        check("part_latency", 64'(k), 64'd9);

        s0 = starts;
        send(4'b0000, OP_A, OP_B);
        wait_valid(k);
        check("empty_data", out_data, 64'h0);
        check("empty_latency", 64'(k), 64'd1);
        check("empty_starts", 64'(starts - s0), 64'd0);

        hold = 1'b1;
        send(4'b0001, OP_A, OP_B);
        for (int i = 0; i < 5; i++) begin
            check("bp_unit_start", 64'(unit_start), 64'd0);
            check("bp_state", 64'(dut.state == ST_VEC_SEQ_ISSUE), 64'd1);
            @(negedge clk);
        end
        hold = 1'b0;
        wait_valid(k);
        check("bp_data", out_data, 64'h0000_0000_0000_4040);

        s0 = starts;
        send(4'b1111, OP_A, OP_B);
        @(negedge clk);
        check("busy_accept", 64'(out_can_accept_cmd), 64'd0);
        in_start = 1'b1;
        in_lane_mask = 4'b0010;
        in_a = '1;
        in_b = '1;
        @(negedge clk);
        in_start = 1'b0;
        wait_valid(k);
        check("busy_ignored_data", out_data, RES_FULL);
        check("busy_ignored_starts", 64'(starts - s0), 64'd4);
        send(4'b0101, OP_A, OP_B);
        check("restart_valid_drop", 64'(out_data_valid), 64'd0);
        wait_valid(k);
        check("restart_data", out_data, RES_PART);

        lat = 3;
        send(4'b1111, OP_A, OP_B);
        n = 0;
        while (!(dut.state == ST_VEC_SEQ_WAIT && dut.lane == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_lane1", 64'(dut.state == ST_VEC_SEQ_WAIT && dut.lane == 2'd1), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_accept", 64'(out_can_accept_cmd), 64'd1);
        check("mid_rst_valid", 64'(out_data_valid), 64'd0);
        check("mid_rst_data", out_data, 64'h0);
        check("mid_rst_unit_start", 64'(unit_start), 64'd0);
        check("mid_rst_state", 64'(dut.state == ST_VEC_SEQ_IDLE), 64'd1);
        lat = 1;
        s0 = starts;
        send(4'b1111, OP_A, OP_B);
        wait_valid(k);
        check("post_rst_data", out_data, RES_FULL);
        check("post_rst_starts", 64'(starts - s0), 64'd4);
        check("post_rst_latency", 64'(k), 64'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
